// File: rtl/sysid_pkg.sv
// ============================================================================
// sysid_pkg : shared types and constants for the System ID reader.
// Rev 1.0
// ============================================================================
`default_nettype none

package sysid_pkg;

   typedef enum logic [2:0] {
      AUTO  = 3'd0,
      IDLE  = 3'd1,
      RD_ID = 3'd2,
      RD_TS = 3'd3,
      CMP   = 3'd4,
      FIN   = 3'd5
   } state_t;

   localparam int unsigned SYSID_ID_OFS = 0;
   localparam int unsigned SYSID_TS_OFS = 4;

   localparam logic [31:0] SYSID_DEF_EXPECTED_ID = 32'h0000_0000;
   localparam logic [31:0] SYSID_DEF_EXPECTED_TS = 32'd1522719104;

   function automatic logic sysid_is_busy(input state_t s);
      return (s == AUTO) || (s == RD_ID) || (s == RD_TS) || (s == CMP);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sysid_stall_timer.sv
// ============================================================================
// sysid_stall_timer : waitrequest stall counter with clear and limit flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module sysid_stall_timer #(
   parameter int unsigned LIMIT = 256
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic inc_i,
   output logic at_limit_o
);

   localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign at_limit_o = (count_q == CNT_W'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/sysid_reader.sv
// ============================================================================
// sysid_reader : Avalon-MM master that reads the SysID ID/timestamp words and
// checks them against expected values. SYSID_TS_CHECK_EN adds the timestamp
// to the match condition.
// Rev 1.0
// ============================================================================
`default_nettype none

module sysid_reader
   import sysid_pkg::*;
#(
   parameter int unsigned        ADDR_W         = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR      = '0,
   parameter logic [31:0]        EXPECTED_ID    = SYSID_DEF_EXPECTED_ID,
   parameter logic [31:0]        EXPECTED_TS    = SYSID_DEF_EXPECTED_TS,
   parameter int unsigned        TIMEOUT_CYCLES = 256
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_waitrequest,
   output logic [31:0]       id_value,
   output logic [31:0]       ts_value,
   output logic              busy,
   output logic              done,
   output logic              match,
   output logic              timeout
);

`ifdef SYSID_TS_CHECK_EN
   localparam bit TS_CHECK = 1'b1;
`else
   localparam bit TS_CHECK = 1'b0;
`endif

   state_t             state_q, state_d;
   logic               read_q, read_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [31:0]        id_q, id_d;
   logic [31:0]        ts_q, ts_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               match_q, match_d;
   logic               timeout_q, timeout_d;

   logic               xfer_done;
   logic               stall_abort;
   logic               at_limit;
   logic               check_ok;

   assign xfer_done   = read_q && !avm_waitrequest;
   assign stall_abort = read_q && avm_waitrequest && at_limit;
   assign check_ok    = (id_q == EXPECTED_ID) && (!TS_CHECK || (ts_q == EXPECTED_TS));

   // Held at zero outside the read states, so every read state starts fresh.
   sysid_stall_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_stall_timer (
      .clock      (clock),
      .reset      (reset),
      .clear_i    (!read_q || xfer_done),
      .inc_i      (read_q && avm_waitrequest),
      .at_limit_o (at_limit)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= AUTO;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         AUTO:    state_d = RD_ID;
         IDLE:    if (start) state_d = RD_ID;
         RD_ID:   if (xfer_done) state_d = RD_TS; else if (stall_abort) state_d = FIN;
         RD_TS:   if (xfer_done) state_d = CMP;   else if (stall_abort) state_d = FIN;
         CMP:     state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      read_d    = (state_d == RD_ID) || (state_d == RD_TS);
      addr_d    = BASE_ADDR + ((state_d == RD_TS) ? ADDR_W'(SYSID_TS_OFS) : ADDR_W'(SYSID_ID_OFS));
      busy_d    = sysid_is_busy(state_d);
      done_d    = (state_d == FIN);
      id_d      = id_q;
      ts_d      = ts_q;
      match_d   = match_q;
      timeout_d = timeout_q;

      if ((state_q == RD_ID) && xfer_done) id_d = avm_readdata;
      if ((state_q == RD_TS) && xfer_done) ts_d = avm_readdata;

      if ((state_d == RD_ID) && (state_q != RD_ID)) begin
         match_d   = 1'b0;
         timeout_d = 1'b0;
      end
      if (state_q == CMP) match_d = check_ok;
      if (stall_abort) begin
         match_d   = 1'b0;
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         read_q    <= 1'b0;
         addr_q    <= BASE_ADDR;
         id_q      <= '0;
         ts_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         match_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         read_q    <= read_d;
         addr_q    <= addr_d;
         id_q      <= id_d;
         ts_q      <= ts_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         match_q   <= match_d;
         timeout_q <= timeout_d;
      end
   end

   assign avm_address = addr_q;
   assign avm_read    = read_q;
   assign id_value    = id_q;
   assign ts_value    = ts_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign match       = match_q;
   assign timeout     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_sysid_reader.sv
// ============================================================================
// tb_sysid_reader : randomized bench with an Avalon slave model and a
// scoreboard of expected check outcomes.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sysid_reader;

   localparam int          T      = 8;
   localparam logic [31:0] BASE   = 32'h0000_0040;
   localparam logic [31:0] EXP_ID = 32'h0000_0000;
   localparam logic [31:0] EXP_TS = 32'd1522719104;
`ifdef SYSID_TS_CHECK_EN
   localparam bit TSCHK = 1'b1;
`else
   localparam bit TSCHK = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata = '0;
   logic        avm_waitrequest = 1'b0;
   logic [31:0] id_value, ts_value;
   logic        busy, done, match, timeout;

   sysid_reader #(
      .ADDR_W         (32),
      .BASE_ADDR      (BASE),
      .EXPECTED_ID    (EXP_ID),
      .EXPECTED_TS    (EXP_TS),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest),
      .id_value        (id_value),
      .ts_value        (ts_value),
      .busy            (busy),
      .done            (done),
      .match           (match),
      .timeout         (timeout)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] id;
      logic [31:0] ts;
      logic        match;
      logic        tmo;
      int          rd_cycles;
   } exp_t;

   exp_t        sb[$];
   int          n_checks  = 0;
   int          n_fail    = 0;
   int          done_seen = 0;

   // Slave configuration for the current check and the model's captured words.
   logic [31:0] s_id = '0, s_ts = '0;
   int          s_stall_id = 0, s_stall_ts = 0, c_id = 0, c_ts = 0;
   logic [31:0] m_id = '0, m_ts = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected outcome derived from the rules: a word stalled T or more cycles aborts.
   task automatic plan(input logic [31:0] id, input logic [31:0] ts, input int sid, input int sts);
      exp_t e;
      s_id = id; s_ts = ts; s_stall_id = sid; s_stall_ts = sts; c_id = 0; c_ts = 0;
      if (sid >= T) begin
         e.tmo = 1'b1; e.match = 1'b0; e.rd_cycles = T;
      end else begin
         m_id = id;
         if (sts >= T) begin
            e.tmo = 1'b1; e.match = 1'b0; e.rd_cycles = sid + 1 + T;
         end else begin
            m_ts = ts;
            e.tmo = 1'b0;
            e.match = (id == EXP_ID) && (!TSCHK || (ts == EXP_TS));
            e.rd_cycles = sid + 1 + sts + 1;
         end
      end
      e.id = m_id; e.ts = m_ts;
      sb.push_back(e);
   endtask

   // Avalon slave: drives a new response just after each active edge.
   always @(posedge clock) begin
      #1;
      if (avm_read && !reset) begin
         if (avm_address == BASE) begin
            if (c_id < s_stall_id) begin avm_waitrequest = 1'b1; c_id++; avm_readdata = $urandom; end
            else begin avm_waitrequest = 1'b0; avm_readdata = s_id; end
         end else if (avm_address == BASE + 32'd4) begin
            if (c_ts < s_stall_ts) begin avm_waitrequest = 1'b1; c_ts++; avm_readdata = $urandom; end
            else begin avm_waitrequest = 1'b0; avm_readdata = s_ts; end
         end else begin
            avm_waitrequest = 1'b0; avm_readdata = $urandom;
         end
      end else begin
         avm_waitrequest = 1'($urandom_range(0, 1));
         avm_readdata    = $urandom;
      end
   end

   // Monitor: bus stability during stalls and scoreboard pop on each done.
   logic        prev_stall = 1'b0;
   logic        prev_done  = 1'b0;
   logic [31:0] prev_addr  = '0;
   int          rd_cnt     = 0;

   always @(negedge clock) begin
      if (reset) begin
         prev_stall = 1'b0; prev_done = 1'b0; rd_cnt = 0;
      end else begin
         if (prev_stall)
            chk("stall_hold", 32'((avm_read && avm_address == prev_addr) || (!avm_read && timeout)), 32'd1);
         prev_stall = avm_read && avm_waitrequest;
         prev_addr  = avm_address;
         if (avm_read) rd_cnt++;
         if (done) begin
            exp_t e;
            done_seen++;
            chk("done_single", 32'(prev_done), 32'd0);
            chk("busy_at_done", 32'(busy), 32'd0);
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("id_value", id_value, e.id);
               chk("ts_value", ts_value, e.ts);
               chk("match", 32'(match), 32'(e.match));
               chk("timeout", 32'(timeout), 32'(e.tmo));
               chk("read_cycles", 32'(rd_cnt), 32'(e.rd_cycles));
            end
            rd_cnt = 0;
         end
         prev_done = done;
      end
   end

   task automatic wait_done(input int target);
      for (int i = 0; i < 300 && done_seen < target; i++) @(posedge clock);
      @(negedge clock);
      chk("done_count", 32'(done_seen), 32'(target));
   endtask

   task automatic run(input logic [31:0] id, input logic [31:0] ts, input int sid, input int sts,
                      input bit extra_start);
      int tgt;
      plan(id, ts, sid, sts);
      tgt = done_seen + 1;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      if (extra_start) begin
         repeat (2) @(negedge clock);
         start = 1'b1;
         @(negedge clock); start = 1'b0;
      end
      wait_done(tgt);
      repeat (3) @(negedge clock);
      chk("idle_after_check", {30'd0, avm_read, busy}, 32'd0);
   endtask

   function automatic int pick_stall();
      int sel = int'($urandom_range(0, 9));
      if (sel < 6)  return int'($urandom_range(0, 3));
      if (sel == 6) return T - 1;
      if (sel == 7) return T;
      if (sel == 8) return int'($urandom_range(4, T - 2));
      return T + int'($urandom_range(0, 5));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rid, rts;
      int          tgt;

      plan(EXP_ID, EXP_TS, 0, 0);
      repeat (3) @(negedge clock);
      chk("rst_read", 32'(avm_read), 32'd0);
      chk("rst_addr", avm_address, BASE);
      chk("rst_id", id_value, 32'd0);
      chk("rst_ts", ts_value, 32'd0);
      chk("rst_flags", {28'd0, busy, done, match, timeout}, 32'd0);
      reset = 1'b0;
      wait_done(1);
      repeat (3) @(negedge clock);

      run(32'h0000_0001, EXP_TS, 0, 0, 1'b0);
      run(EXP_ID, EXP_TS, 0, 0, 1'b1);
      run(EXP_ID, EXP_TS, 3, 3, 1'b0);
      run(EXP_ID, 32'd5, 0, 0, 1'b0);
      run(EXP_ID, EXP_TS, 0, 1000, 1'b0);
      run(EXP_ID, EXP_TS, 1000, 0, 1'b0);
      run(EXP_ID, EXP_TS, T - 1, T - 1, 1'b0);
      run(EXP_ID, EXP_TS, T, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         rid = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
         rts = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
         run(rid, rts, pick_stall(), pick_stall(), 1'($urandom_range(0, 1)));
      end

      // Reset while the timestamp read is stalled, then let the auto check rerun.
      plan(EXP_ID, EXP_TS, 0, 1000);
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      for (int i = 0; i < 50 && !(avm_read && avm_address == BASE + 32'd4); i++) @(negedge clock);
      chk("reached_rd_ts", {31'd0, avm_read}, 32'd1);
      repeat (2) @(negedge clock);
      #1 reset = 1'b1;
      sb.delete();
      m_id = '0; m_ts = '0;
      plan(EXP_ID, EXP_TS, 1, 2);
      @(negedge clock);
      chk("midrst_read", 32'(avm_read), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_id", id_value, 32'd0);
      @(negedge clock);
      tgt = done_seen + 1;
      reset = 1'b0;
      wait_done(tgt);
      chk("midrst_match", 32'(match), 32'd1);
      repeat (3) @(negedge clock);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
